// File: rtl/cmpl_mult_arbiter.sv
// cmpl_mult_arbiter: round-robin front end that time-shares one pipelined
//   complex multiplier among NUM_REQ requesters and routes products back.
// Latency: accept edge -> mult_ivalid next cycle; product -> rsp_valid next cycle.
// Backpressure: req_ready drops while the tag FIFO is full; responses have none.
// Ports: clock/reset (sync, active-high); req_* per-requester operand handshake;
//   mult_* issue/return path to the shared multiplier; rsp_* routed product;
//   in_flight outstanding multiplies; tag_err sticky orphan-product flag.
module cmpl_mult_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int IN_WIDTH  = 16,
  parameter  int OUT_WIDTH = 32,
  parameter  int TAG_DEPTH = 8,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int AW        = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1,
  localparam int CW        = $clog2(TAG_DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_a_r,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_b_r,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_b_i,
  output logic                        mult_ivalid,
  output logic [IN_WIDTH-1:0]         mult_a_r,
  output logic [IN_WIDTH-1:0]         mult_a_i,
  output logic [IN_WIDTH-1:0]         mult_b_r,
  output logic [IN_WIDTH-1:0]         mult_b_i,
  input  logic                        mult_ovalid,
  input  logic [OUT_WIDTH-1:0]        mult_result_r,
  input  logic [OUT_WIDTH-1:0]        mult_result_i,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [OUT_WIDTH-1:0]        rsp_r,
  output logic [OUT_WIDTH-1:0]        rsp_i,
  output logic [IDW-1:0]              rsp_id,
  output logic [CW-1:0]               in_flight,
  output logic                        tag_err
);

  logic [IDW-1:0]       r_ptr;
  logic                 r_mult_vld;
  logic [IN_WIDTH-1:0]  r_a_r, r_a_i, r_b_r, r_b_i;
  logic [IDW-1:0]       r_tag_mem [TAG_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_rsp_vld;
  logic [IDW-1:0]       r_rsp_id;
  logic [OUT_WIDTH-1:0] r_rsp_r, r_rsp_i;
  logic                 r_tag_err;

  logic                 w_full, w_found, w_acc, w_pop;
  logic [IDW:0]         w_sum;
  logic [IDW-1:0]       w_idx, w_gnt_id, w_ptr_nxt, w_pop_tag;
  logic [NUM_REQ-1:0]   w_gnt, w_pop_oh;
  logic [IN_WIDTH-1:0]  w_sel_a_r, w_sel_a_i, w_sel_b_r, w_sel_b_i;

  // Full is derived from the registered count only, so a pop in the same
  // cycle cannot reopen acceptance until the following cycle.
  assign w_full = (r_cnt == CW'(TAG_DEPTH));

  // Rotating priority search starting at r_ptr; the sum is one bit wider
  // than the index so the modulo wrap is a single conditional subtract.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NUM_REQ)) w_sum = w_sum - (IDW+1)'(NUM_REQ);
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  assign w_acc     = w_found && !w_full && !reset;
  assign w_ptr_nxt = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);
  assign w_pop     = mult_ovalid && (r_cnt != '0);
  assign w_pop_tag = r_tag_mem[r_rd_ptr];

  always_comb begin
    w_gnt     = '0;
    w_pop_oh  = '0;
    w_sel_a_r = '0;
    w_sel_a_i = '0;
    w_sel_b_r = '0;
    w_sel_b_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt[k]    = w_acc && (w_gnt_id == IDW'(k));
      w_pop_oh[k] = (w_pop_tag == IDW'(k));
      if (w_gnt_id == IDW'(k)) begin
        w_sel_a_r = req_a_r[k*IN_WIDTH +: IN_WIDTH];
        w_sel_a_i = req_a_i[k*IN_WIDTH +: IN_WIDTH];
        w_sel_b_r = req_b_r[k*IN_WIDTH +: IN_WIDTH];
        w_sel_b_i = req_b_i[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Tag storage needs no reset: validity is tracked by the pointers/count.
  always_ff @(posedge clock) begin
    if (w_acc) r_tag_mem[r_wr_ptr] <= w_gnt_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_mult_vld <= 1'b0;
      r_a_r      <= '0;
      r_a_i      <= '0;
      r_b_r      <= '0;
      r_b_i      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_rsp_vld  <= '0;
      r_rsp_id   <= '0;
      r_rsp_r    <= '0;
      r_rsp_i    <= '0;
      r_tag_err  <= 1'b0;
    end else begin
      r_mult_vld <= w_acc;
      if (w_acc) begin
        r_a_r    <= w_sel_a_r;
        r_a_i    <= w_sel_a_i;
        r_b_r    <= w_sel_b_r;
        r_b_i    <= w_sel_b_i;
        r_ptr    <= w_ptr_nxt;
        r_wr_ptr <= (r_wr_ptr == AW'(TAG_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(TAG_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
        r_rsp_id <= w_pop_tag;
        r_rsp_r  <= mult_result_r;
        r_rsp_i  <= mult_result_i;
      end
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_rsp_vld <= w_pop ? w_pop_oh : '0;
      // A product with no outstanding tag has no owner; flag it and drop it.
      if (mult_ovalid && (r_cnt == '0)) r_tag_err <= 1'b1;
    end
  end

  assign req_ready   = w_gnt;
  assign mult_ivalid = r_mult_vld;
  assign mult_a_r    = r_a_r;
  assign mult_a_i    = r_a_i;
  assign mult_b_r    = r_b_r;
  assign mult_b_i    = r_b_i;
  assign rsp_valid   = r_rsp_vld;
  assign rsp_id      = r_rsp_id;
  assign rsp_r       = r_rsp_r;
  assign rsp_i       = r_rsp_i;
  assign in_flight   = r_cnt;
  assign tag_err     = r_tag_err;

endmodule

// File: tb/tb_cmpl_mult_arbiter.sv
// tb_cmpl_mult_arbiter: directed bench for the shared-multiplier arbiter,
//   with a 3-stage complex multiplier model that can be stalled or overridden.
// Checks go through check_eq; one summary line at the end.
module tb_cmpl_mult_arbiter;

  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a_r, req_a_i, req_b_r, req_b_i;
  logic        mult_ivalid;
  logic [15:0] mult_a_r, mult_a_i, mult_b_r, mult_b_i;
  logic        mult_ovalid;
  logic [31:0] mult_result_r, mult_result_i;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_r, rsp_i;
  logic [1:0]  rsp_id;
  logic [3:0]  in_flight;
  logic        tag_err;

  // multiplier model controls
  logic        stall, inj_v;
  logic [31:0] inj_r, inj_i;
  logic [L-1:0] m_v;
  logic [31:0]  m_r [L];
  logic [31:0]  m_i [L];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct { int id; int cyc; } gnt_t;
  typedef struct { logic [3:0] vld; int id; logic [31:0] r; logic [31:0] i; int cyc; } rsp_t;
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  always #5 clock = ~clock;

  cmpl_mult_arbiter #(.NUM_REQ(4), .IN_WIDTH(16), .OUT_WIDTH(32), .TAG_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_r(req_a_r), .req_a_i(req_a_i), .req_b_r(req_b_r), .req_b_i(req_b_i),
    .mult_ivalid(mult_ivalid),
    .mult_a_r(mult_a_r), .mult_a_i(mult_a_i), .mult_b_r(mult_b_r), .mult_b_i(mult_b_i),
    .mult_ovalid(mult_ovalid), .mult_result_r(mult_result_r), .mult_result_i(mult_result_i),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_i(rsp_i), .rsp_id(rsp_id),
    .in_flight(in_flight), .tag_err(tag_err)
  );

  always_ff @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_v <= '0;
      for (int s = 0; s < L; s++) begin
        m_r[s] <= '0;
        m_i[s] <= '0;
      end
    end else begin
      m_v    <= {m_v[L-2:0], mult_ivalid};
      m_r[0] <= $signed(mult_a_r) * $signed(mult_b_r) - $signed(mult_a_i) * $signed(mult_b_i);
      m_i[0] <= $signed(mult_a_r) * $signed(mult_b_i) + $signed(mult_a_i) * $signed(mult_b_r);
      for (int s = 1; s < L; s++) begin
        m_r[s] <= m_r[s-1];
        m_i[s] <= m_i[s-1];
      end
    end
  end

  assign mult_ovalid   = inj_v | (m_v[L-1] & ~stall);
  assign mult_result_r = inj_v ? inj_r : m_r[L-1];
  assign mult_result_i = inj_v ? inj_i : m_i[L-1];

  // Log grants and responses observed at the falling edge.
  always @(negedge clock) begin
    gnt_t g;
    rsp_t r;
    if (!reset && ((req_valid & req_ready) != 4'b0)) begin
      g.id = -1;
      for (int k = 0; k < 4; k++) if (req_ready[k]) g.id = k;
      g.cyc = cyc;
      gnt_q.push_back(g);
    end
    if (rsp_valid != 4'b0) begin
      r.vld = rsp_valid;
      r.id  = int'(rsp_id);
      r.r   = rsp_r;
      r.i   = rsp_i;
      r.cyc = cyc;
      rsp_q.push_back(r);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic set_ops(input int k, input int ar, input int ai, input int br, input int bi);
    req_a_r[k*16 +: 16] = 16'(ar);
    req_a_i[k*16 +: 16] = 16'(ai);
    req_b_r[k*16 +: 16] = 16'(br);
    req_b_i[k*16 +: 16] = 16'(bi);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 40) begin
      @(negedge clock);
      #1;
      k++;
    end
    check_eq(tag, rsp_q.size(), n);
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 4'hF; stall = 1'b0; inj_v = 1'b0;
    inj_r = '0; inj_i = '0;
    req_a_r = '0; req_a_i = '0; req_b_r = '0; req_b_i = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", req_ready, 4'b0);
    check_eq("rst_ivalid", mult_ivalid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_in_flight", in_flight, 0);
    check_eq("rst_tag_err", tag_err, 0);
    @(posedge clock);
    #1 reset = 1'b0; req_valid = 4'b0;
    clear_logs();

    // 1: single request, (3+4j)(1+2j) = -5+10j
    set_ops(0, 3, 4, 1, 2);
    req_valid = 4'b0001;
    @(negedge clock);
    check_eq("t1_ready", req_ready, 4'b0001);
    @(posedge clock);
    #1 req_valid = 4'b0;
    @(negedge clock);
    check_eq("t1_ivalid", mult_ivalid, 1);
    check_eq("t1_a_r", mult_a_r, 3);
    check_eq("t1_a_i", mult_a_i, 4);
    check_eq("t1_b_r", mult_b_r, 1);
    check_eq("t1_b_i", mult_b_i, 2);
    check_eq("t1_in_flight", in_flight, 1);
    @(negedge clock);
    check_eq("t1_ivalid_pulse", mult_ivalid, 0);
    wait_rsp(1, "t1_rsp_cnt");
    check_eq("t1_gnt_cnt", gnt_q.size(), 1);
    if (rsp_q.size() >= 1 && gnt_q.size() >= 1) begin
      check_eq("t1_rsp_vld", rsp_q[0].vld, 4'b0001);
      check_eq("t1_rsp_id", rsp_q[0].id, 0);
      check_eq("t1_rsp_r", rsp_q[0].r, -5);
      check_eq("t1_rsp_i", rsp_q[0].i, 10);
      check_eq("t1_latency", rsp_q[0].cyc - gnt_q[0].cyc, L + 2);
    end
    repeat (3) @(negedge clock);
    #1;
    check_eq("t1_in_flight_end", in_flight, 0);
    check_eq("t1_rsp_single", rsp_q.size(), 1);

    // 2: all four requesters, pointer restarted at 0
    @(posedge clock);
    #1 do_reset();
    clear_logs();
    set_ops(0, 1, 1, 1, 1);   // 0+2j
    set_ops(1, 7, 8, 5, 6);   // -13+82j
    set_ops(2, 2, 0, 3, 0);   // 6+0j
    set_ops(3, 0, 1, 0, 1);   // -1+0j
    req_valid = 4'hF;
    repeat (4) @(posedge clock);
    #1 req_valid = 4'b0;
    check_eq("t2_gnt_cnt", gnt_q.size(), 4);
    if (gnt_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq($sformatf("t2_gnt%0d", k), gnt_q[k].id, k);
      check_eq("t2_gnt_span", gnt_q[3].cyc - gnt_q[0].cyc, 3);
    end
    wait_rsp(4, "t2_rsp_cnt");
    if (rsp_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq($sformatf("t2_rsp_id%0d", k), rsp_q[k].id, k);
      check_eq("t2_req1_r", rsp_q[1].r, -13);
      check_eq("t2_req1_i", rsp_q[1].i, 82);
      check_eq("t2_req3_r", rsp_q[3].r, -1);
      check_eq("t2_req0_i", rsp_q[0].i, 2);
    end

    // 3: requesters 1 and 3 alternate
    @(posedge clock);
    #1 clear_logs();
    req_valid = 4'b1010;
    repeat (4) @(posedge clock);
    #1 req_valid = 4'b0;
    check_eq("t3_gnt_cnt", gnt_q.size(), 4);
    if (gnt_q.size() >= 4) begin
      check_eq("t3_gnt0", gnt_q[0].id, 1);
      check_eq("t3_gnt1", gnt_q[1].id, 3);
      check_eq("t3_gnt2", gnt_q[2].id, 1);
      check_eq("t3_gnt3", gnt_q[3].id, 3);
    end
    wait_rsp(4, "t3_rsp_cnt");

    // 4: negative operands, (-3+2j)(4-1j) = -10+11j
    @(posedge clock);
    #1 clear_logs();
    set_ops(2, -3, 2, 4, -1);
    req_valid = 4'b0100;
    @(posedge clock);
    #1 req_valid = 4'b0;
    wait_rsp(1, "t4_rsp_cnt");
    if (rsp_q.size() >= 1) begin
      check_eq("t4_rsp_vld", rsp_q[0].vld, 4'b0100);
      check_eq("t4_rsp_id", rsp_q[0].id, 2);
      check_eq("t4_rsp_r", rsp_q[0].r, 32'hFFFF_FFF6);
      check_eq("t4_rsp_i", rsp_q[0].i, 11);
    end

    // 5: stalled multiplier fills the tag FIFO (pointer at 3 -> first tag 3)
    @(posedge clock);
    #1 clear_logs();
    stall = 1'b1;
    req_valid = 4'hF;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check_eq("t5_accepts", gnt_q.size(), 8);
    check_eq("t5_ready_full", req_ready, 4'b0);
    check_eq("t5_in_flight", in_flight, 8);
    @(posedge clock);
    #1 inj_v = 1'b1; inj_r = 32'h0001_2345; inj_i = -7;
    @(negedge clock);
    check_eq("t5_full_hold", req_ready, 4'b0);
    @(posedge clock);
    #1 inj_v = 1'b0;
    @(negedge clock);
    check_eq("t5_reopen", req_ready, 4'b1000);
    check_eq("t5_in_flight_pop", in_flight, 7);
    check_eq("t5_rsp_vld", rsp_valid, 4'b1000);
    check_eq("t5_rsp_id", rsp_id, 3);
    check_eq("t5_rsp_r", rsp_r, 32'h0001_2345);
    check_eq("t5_rsp_i", rsp_i, -7);
    @(posedge clock);
    #1 req_valid = 4'b0;
    @(negedge clock);
    check_eq("t5_in_flight_refill", in_flight, 8);
    check_eq("t5_accepts_total", gnt_q.size(), 9);

    // 6: orphan product, then reset in the middle of a stream
    @(posedge clock);
    #1 do_reset();
    stall = 1'b0;
    clear_logs();
    @(negedge clock);
    check_eq("t6_in_flight_rst", in_flight, 0);
    @(posedge clock);
    #1 inj_v = 1'b1; inj_r = 5; inj_i = 5;
    @(posedge clock);
    #1 inj_v = 1'b0;
    @(negedge clock);
    check_eq("t6_tag_err", tag_err, 1);
    check_eq("t6_no_rsp", rsp_valid, 0);
    check_eq("t6_in_flight", in_flight, 0);
    repeat (3) @(negedge clock);
    #1;
    check_eq("t6_tag_err_sticky", tag_err, 1);
    check_eq("t6_rsp_none", rsp_q.size(), 0);
    @(posedge clock);
    #1 req_valid = 4'hF;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("t6_ready_in_rst", req_ready, 4'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("t6_rst_ivalid", mult_ivalid, 0);
    check_eq("t6_rst_a_r", mult_a_r, 0);
    check_eq("t6_rst_rsp_vld", rsp_valid, 0);
    check_eq("t6_rst_rsp_r", rsp_r, 0);
    check_eq("t6_rst_in_flight", in_flight, 0);
    check_eq("t6_rst_tag_err", tag_err, 0);
    check_eq("t6_ptr_restart", req_ready, 4'b0001);
    @(posedge clock);
    #1 req_valid = 4'b0;
    repeat (8) @(negedge clock);
    #1;
    check_eq("t6_drain_in_flight", in_flight, 0);
    check_eq("t6_drain_tag_err", tag_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
